// File: rtl/mmu_skew_feeder.sv
// Tile buffer and diagonal skew feeder for the NxN systolic multiply array.
// Define MMU_FEEDER_DBUF_EN for ping-pong banks so loading overlaps streaming.
module mmu_skew_feeder #(
  parameter int N         = 4,
  parameter int bit_width = 8,
  parameter int DRAIN     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*bit_width-1:0] in_data,
  input  logic [N*bit_width-1:0] in_wt,
  output logic [N*bit_width-1:0] data_arr,
  output logic [N*bit_width-1:0] wt_arr,
  output logic                   mmu_control,
  output logic                   tile_done,
  output logic [7:0]             tile_cnt
);

`ifdef MMU_FEEDER_DBUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(2*N - 1 + DRAIN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N - 1);
  localparam logic [CNT_W-1:0]  T_LAST    = CNT_W'(2*N - 2);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(2*N - 2 + DRAIN);

  typedef enum logic [1:0] {ST_LOAD, ST_STREAM, ST_DRAIN, ST_DONE} state_t;

  state_t                 state, state_nxt;
  logic [BEAT_W-1:0]      beat, beat_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [NBANK-1:0]       full, full_nxt;
  logic                   ld_bank, ld_bank_nxt;
  logic                   st_bank, st_bank_nxt;
  logic                   accept, load_last, alt_ready;
  logic [N*bit_width-1:0] data_nxt, wt_nxt;
  logic                   ctrl_nxt, done_nxt, ready_nxt;

  logic [N*bit_width-1:0] buf_a [NBANK][N];
  logic [N*bit_width-1:0] buf_w [NBANK][N];

  assign accept    = in_valid && in_ready;
  assign load_last = accept && (beat == BEAT_LAST);

`ifdef MMU_FEEDER_DBUF_EN
  // The bank being filled may complete on the same edge DONE is evaluated.
  assign alt_ready = full[~st_bank] || (load_last && (ld_bank != st_bank));
`else
  assign alt_ready = 1'b0;
`endif

  // Stage: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_LOAD;
      beat    <= '0;
      cnt     <= '0;
      full    <= '0;
      ld_bank <= 1'b0;
      st_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      cnt     <= cnt_nxt;
      full    <= full_nxt;
      ld_bank <= ld_bank_nxt;
      st_bank <= st_bank_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_a[ld_bank][beat] <= in_data;
      buf_w[ld_bank][beat] <= in_wt;
    end
  end

  // Stage: next-state and bookkeeping
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:   if (load_last) state_nxt = ST_STREAM;
      ST_STREAM: if (cnt == T_LAST) state_nxt = (DRAIN > 0) ? ST_DRAIN : ST_DONE;
      ST_DRAIN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = alt_ready ? ST_STREAM : ST_LOAD;
      default:   state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    beat_nxt    = beat;
    full_nxt    = full;
    ld_bank_nxt = ld_bank;
    st_bank_nxt = st_bank;
    if (accept) beat_nxt = load_last ? '0 : beat + BEAT_W'(1);
    if (state == ST_DONE) full_nxt[st_bank] = 1'b0;
    if (load_last) full_nxt[ld_bank] = 1'b1;
    if (state == ST_LOAD && load_last) st_bank_nxt = ld_bank;
`ifdef MMU_FEEDER_DBUF_EN
    if (load_last) ld_bank_nxt = ~ld_bank;
    if (state == ST_DONE && alt_ready) st_bank_nxt = ~st_bank;
`endif
    cnt_nxt = '0;
    if ((state_nxt == ST_STREAM || state_nxt == ST_DRAIN) &&
        (state == ST_STREAM || state == ST_DRAIN))
      cnt_nxt = cnt + CNT_W'(1);
  end

  // Stage: output decode, lane i of stream cycle t carries row t-i
  always_comb begin
    data_nxt = '0;
    wt_nxt   = '0;
    if (state_nxt == ST_STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (int'(cnt_nxt) == i + j) begin
            data_nxt[i*bit_width +: bit_width] = buf_a[st_bank_nxt][BEAT_W'(j)][i*bit_width +: bit_width];
            wt_nxt[i*bit_width +: bit_width]   = buf_w[st_bank_nxt][BEAT_W'(j)][i*bit_width +: bit_width];
          end
        end
      end
    end
    ctrl_nxt  = (state_nxt == ST_STREAM) || (state_nxt == ST_DRAIN);
    done_nxt  = (state_nxt == ST_DONE);
    ready_nxt = !full_nxt[ld_bank_nxt];
  end

  // Stage: output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      data_arr    <= '0;
      wt_arr      <= '0;
      mmu_control <= 1'b0;
      tile_done   <= 1'b0;
      in_ready    <= 1'b1;
      tile_cnt    <= '0;
    end else begin
      data_arr    <= data_nxt;
      wt_arr      <= wt_nxt;
      mmu_control <= ctrl_nxt;
      tile_done   <= done_nxt;
      in_ready    <= ready_nxt;
      if (state == ST_DONE) tile_cnt <= tile_cnt + 8'd1;
    end
  end

endmodule

// File: doc/mmu_skew_feeder.md
# mmu_skew_feeder

Input-side feeder for the 4x4 systolic matrix-multiply array. It accepts one tile of activation rows and weight rows over a valid/ready load interface and buffers the whole tile. It then replays the tile as diagonally skewed lane streams on `data_arr`/`wt_arr`, holding the array's `control` high throughout. It sits directly upstream of the array and produces exactly the lane-packed, zero-padded stimulus the array consumes.

## Interface
Parameters:
- `N`, 4: array dimension; lanes per beat, beats per tile.
- `bit_width`, 8: element width.
- `DRAIN`, 8: zero-fill cycles after the skewed stream, so the accumulators settle.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  load beat valid.
- `in_ready`  out  1  load beat accepted when `in_valid && in_ready`.
- `in_data`  in  N*bit_width  activation beat; lane i = bits [i*bit_width +: bit_width].
- `in_wt`  in  N*bit_width  weight beat; same lane packing as `in_data`.
- `data_arr`  out  N*bit_width  skewed activation lanes to the array.
- `wt_arr`  out  N*bit_width  skewed weight lanes to the array.
- `mmu_control`  out  1  array enable; high during STREAM and DRAIN.
- `tile_done`  out  1  one-cycle pulse marking the end of a tile.
- `tile_cnt`  out  8  count of completed tiles; wraps 255→0.

## Operation
- States: LOAD, STREAM, DRAIN, DONE. Reset state is LOAD.
- Reset values: all outputs 0, except `in_ready`, which is 1.
- LOAD:
  - `in_ready`=1.
  - Accepted beat j (0..N-1) is written to `bufA[j]` and `bufW[j]`; the beat counter increments.
  - Acceptance of beat N-1 moves the FSM to STREAM; the beat counter returns to 0.
  - `in_valid` low leaves the FSM in LOAD; partial tiles are held indefinitely.
- STREAM: the stream counter t runs 0..2N-2 (7 cycles at N=4).
  - Output lane i = `bufA[t-i][i]` when 0 ≤ t-i ≤ N-1, else 0; `wt_arr` is formed identically from `bufW`.
  - Equivalently, beat j lane i appears at stream cycle j+i.
  - After t=2N-2 the FSM moves to DRAIN.
- DRAIN: `DRAIN` cycles of all-zero lanes, `mmu_control`=1. The FSM then moves to DONE.
- DONE: one cycle.
  - `tile_done`=1 and `mmu_control`=0.
  - `tile_cnt` increments, taking its new value on the next cycle.
  - Next state is LOAD, or STREAM when double buffering applies and the alternate bank is full.
- Arithmetic: no arithmetic on data; elements pass through bit-exact. Only the counters use arithmetic: beat counter width clog2(N), stream counter width clog2(2N-1+DRAIN).
- Reset asserted mid-STREAM or mid-DRAIN: on the next edge the FSM returns to LOAD; lanes, `mmu_control` and `tile_done` go to 0; beat counter and `tile_cnt` clear. Buffer contents are don't-care.
- `in_valid` while `in_ready`=0: ignored; the source holds the beat stable until it is accepted.

## Timing
- Outputs are registered.
- Beat N-1 accepted at edge c → `mmu_control`=1 and stream t=0 are visible in cycle c+1.
- First non-zero lane-0 element appears in cycle c+1; last lane N-1 element appears at cycle c+2N-1.
- `tile_done` is high in cycle c+2N+DRAIN (c+16 at defaults).
- Minimum tile period without double buffering: N load cycles + 2N-1 + DRAIN + 1 = 20 cycles at defaults.
- `in_ready` is a registered function of state and buffer occupancy only; it has no combinational path from `in_valid`.

## Configuration
- Macro: `MMU_FEEDER_DBUF_EN`.
- Defined:
  - Two buffer banks (ping-pong). `in_ready`=1 whenever the load bank is not full, including during STREAM/DRAIN/DONE.
  - When the load bank fills while the other bank is streaming, the full bank waits. DONE then proceeds directly to STREAM on the full bank, giving back-to-back tiles with a 1-cycle `mmu_control` gap.
  - When both banks are full, `in_ready`=0.
- Undefined:
  - Single bank. `in_ready`=1 only in LOAD; it is 0 in STREAM, DRAIN and DONE.

## Test plan
- Load A rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, W identical → `data_arr` lanes [0..3] over t=0..6:
  - t=0 {1,0,0,0}
  - t=1 {5,2,0,0}
  - t=2 {9,6,3,0}
  - t=3 {13,10,7,4}
  - t=4 {0,14,11,8}
  - t=5 {0,0,15,12}
  - t=6 {0,0,0,16}
  
  Then 8 zero cycles, `tile_done` at c+16, `tile_cnt`=1.
- `in_valid` toggled 1,0,0,1,1,0,1 → exactly 4 beats captured in order; STREAM starts the cycle after the 4th accept.
- Reset asserted at stream t=3 → next cycle all outputs 0, `in_ready`=1, `tile_cnt`=0; a new tile afterwards streams correctly.
- 256 consecutive tiles → `tile_cnt` wraps to 0 after the 256th `tile_done`.
- With `MMU_FEEDER_DBUF_EN`: load tile 2 during tile 1 STREAM → `in_ready` stays 1 through that load; tile 2 t=0 follows tile 1 `tile_done` by 1 cycle. Without the macro: `in_ready`=0 during STREAM, DRAIN and DONE.
- Lane values 0xFF and 0x80 → passed bit-exact on both buses with no sign extension; the all-ones boundary element appears at lane 3, t=6.
